exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Reset is `reset`, synchronous, active-high; clock is `clock`.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 op_a  input  32  operand 1 from the ID/EX register (register rs value).
REQ-005 op_b  input  32  operand 2 from the ID/EX register (register rt value).
REQ-006 rd_in / rs_in / rt_in  input  5 each  destination and source register numbers from ID/EX.
REQ-007 alu_op  input  4  operation code; encodings are in exec_pkg.
REQ-008 valid_in  input  1  the ID/EX contents are a real instruction.
REQ-009 mem_fwd_val  input  32; mem_fwd_rd  input  5; mem_fwd_wen  input  1  EX/MEM forwarding source.
REQ-010 wb_fwd_val  input  32; wb_fwd_rd  input  5; wb_fwd_wen  input  1  MEM/WB forwarding source.
REQ-011 result  output  32  registered ALU result.
REQ-012 hi_out  output  32  registered upper product word of the last MUL.
REQ-013 rd_out  output  5  registered destination register number.
REQ-014 valid_out  output  1  registered result-valid flag.
REQ-015 stall_out  output  1  combinational stall; upstream drives ID/EX wen = ~stall_out.

Function
REQ-016 Operand A = mem_fwd_val if mem_fwd_wen and mem_fwd_rd==rs_in and rs_in!=0; else wb_fwd_val under the same conditions on the WB source; else op_a.
REQ-017 Operand B follows the same rule using rt_in and op_b; the MEM source has priority over the WB source.
REQ-018 ADD, SUB, AND, OR, XOR compute on 32 bits and wrap on overflow, with no flags.
REQ-019 SLT returns 1 if A < B as signed values, else 0.
REQ-020 SLL, SRL, SRA shift A by B[4:0].
REQ-021 Undefined alu_op values produce result 0.
REQ-022 Non-MUL ops have latency 1:
  - valid_in, op and forwarded operands are sampled at edge N.
  - result, rd_out and valid_out are visible after edge N.
  - valid_in=0 gives valid_out=0 after the edge; result and rd_out hold.
REQ-023 FSM states:
  - IDLE: accepts any instruction.
  - MUL: iterating; all inputs ignored.
  - DONE: one cycle; consumes the held MUL.
REQ-024 MUL accept: in IDLE with valid_in and op MUL:
  - stall_out=1 in the same cycle (cycle 0).
  - At the end of cycle 0, the forwarded A/B are latched, the counter clears, and the FSM moves to MUL.
REQ-025 MUL state:
  - stall_out=1.
  - One shift-add iteration per edge, unsigned 32x32->64.
  - At the edge where the counter equals 31, the FSM moves to DONE; result <= product[31:0], hi_out <= product[63:32], rd_out <= latched rd, valid_out <= 1.
REQ-026 DONE state:
  - stall_out=0 and valid_out=1.
  - The still-held MUL is not restarted.
  - The next edge returns the FSM to IDLE; valid_out is cleared unless a new non-MUL instruction is accepted.
REQ-027 MUL timing: stall_out is high for exactly 33 cycles (cycles 0..32), and valid_out is high in cycle 33.
REQ-028 valid_out is 0 throughout the MUL state.
REQ-029 stall_out = (IDLE & valid_in & alu_op==MUL) | MUL state.
REQ-030 A MUL with A or B equal to 0 still takes the full 33 stall cycles.
REQ-031 A DONE cycle followed immediately by another MUL produces a fresh 33-cycle stall.

Reset
REQ-032 Reset clears: result=0, hi_out=0, rd_out=0, valid_out=0, FSM=IDLE, counter=0, latched operands=0.
REQ-033 After reset, stall_out=0 unless valid_in & MUL is presented.
REQ-034 Reset during the MUL or DONE state aborts the multiply at that edge; no partial result is ever output.
REQ-035 Reset takes priority over all other updates in the same edge.

Structure
REQ-036 Package exec_pkg holds the alu_op encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, SRA=8, MUL=9.
REQ-037 exec_pkg also holds the FSM state typedef (IDLE, MUL, DONE) and the MUL iteration constant 32.
REQ-038 The iterative multiplier is a sub-module, mul_seq, with start/operands in and busy/done/product[63:0] out.
REQ-039 Forwarding muxes, ALU, FSM and output registers reside in exec_stage.

Verification
REQ-040 ADD: op_a=5, op_b=7, valid_in=1 -> result=12, valid_out=1 one cycle later, stall_out=0 throughout.
REQ-041 Forwarding:
  - rs_in=3, mem_fwd_rd=3, mem_fwd_wen=1, mem_fwd_val=100; wb_fwd_rd=3, wb_fwd_wen=1, wb_fwd_val=200; ADD with op_b=1 -> result=101.
  - Repeat with rs_in=0 -> result=op_a+1.
REQ-042 Signed and shift ops:
  - SLT A=0xFFFFFFFF, B=1 -> result=1.
  - SRA A=0x80000000, B=4 -> result=0xF8000000.
  - ADD 0xFFFFFFFF+1 -> result=0.
REQ-043 MUL A=0xFFFFFFFF, B=2:
  - stall_out high for 33 cycles.
  - valid_out in cycle 33 with result=0xFFFFFFFE and hi_out=1.
  - No restart while the instruction is held.
REQ-044 MUL started, then reset asserted in cycle 10 -> the next cycle shows stall_out=0, valid_out=0, result=0, hi_out=0.
REQ-045 Back-to-back MUL (3x4), then MUL (5x6), then ADD -> results 12, 30, then ADD with a correct one-cycle latency; each MUL stalls 33 cycles.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM states, multiplier sizing.
package exec_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REGW      = 5;
    localparam int unsigned OPW       = 4;
    localparam int unsigned MUL_ITERS = 32;
    localparam int unsigned CNTW      = 5;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;
    localparam logic [OPW-1:0] OP_XOR = 4'd4;
    localparam logic [OPW-1:0] OP_SLT = 4'd5;
    localparam logic [OPW-1:0] OP_SLL = 4'd6;
    localparam logic [OPW-1:0] OP_SRL = 4'd7;
    localparam logic [OPW-1:0] OP_SRA = 4'd8;
    localparam logic [OPW-1:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } exec_state_t;

endpackage

// File: rtl/exec_stage_mul_seq.sv
// Unsigned 32x32->64 shift-add multiplier, one partial product per clock.
module mul_seq
    import exec_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [2*XLEN-1:0]   product
);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [CNTW-1:0]   cnt;
    logic [2*XLEN-1:0] acc_nxt;

    // Product includes the current iteration so the final edge can capture it directly.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : (2*XLEN)'(0));
    end

    assign done    = busy && (cnt == CNTW'(MUL_ITERS - 1));
    assign product = acc_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNTW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            acc    <= '0;
            mcand  <= {XLEN'(0), a};
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and a stalling iterative MUL.
module exec_stage
    import exec_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    input  logic [REGW-1:0]     rd_in,
    input  logic [REGW-1:0]     rs_in,
    input  logic [REGW-1:0]     rt_in,
    input  logic [OPW-1:0]      alu_op,
    input  logic                valid_in,
    input  logic [XLEN-1:0]     mem_fwd_val,
    input  logic [REGW-1:0]     mem_fwd_rd,
    input  logic                mem_fwd_wen,
    input  logic [XLEN-1:0]     wb_fwd_val,
    input  logic [REGW-1:0]     wb_fwd_rd,
    input  logic                wb_fwd_wen,
    output logic [XLEN-1:0]     result,
    output logic [XLEN-1:0]     hi_out,
    output logic [REGW-1:0]     rd_out,
    output logic                valid_out,
    output logic                stall_out
);

    exec_state_t       state;
    exec_state_t       state_nxt;
    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;
    logic [XLEN-1:0]   alu_res;
    logic [4:0]        sh;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [2*XLEN-1:0] mul_prod;
    logic [REGW-1:0]   mul_rd;
    logic              accept_alu;

    // Forwarding: EX/MEM wins over MEM/WB; register 0 is never forwarded.
    always_comb begin
        fwd_a = op_a;
        if (mem_fwd_wen && (mem_fwd_rd == rs_in) && (rs_in != '0)) begin
            fwd_a = mem_fwd_val;
        end else if (wb_fwd_wen && (wb_fwd_rd == rs_in) && (rs_in != '0)) begin
            fwd_a = wb_fwd_val;
        end
        fwd_b = op_b;
        if (mem_fwd_wen && (mem_fwd_rd == rt_in) && (rt_in != '0)) begin
            fwd_b = mem_fwd_val;
        end else if (wb_fwd_wen && (wb_fwd_rd == rt_in) && (rt_in != '0)) begin
            fwd_b = wb_fwd_val;
        end
    end

    assign sh = fwd_b[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = fwd_a + fwd_b;
            OP_SUB:  alu_res = fwd_a - fwd_b;
            OP_AND:  alu_res = fwd_a & fwd_b;
            OP_OR:   alu_res = fwd_a | fwd_b;
            OP_XOR:  alu_res = fwd_a ^ fwd_b;
            OP_SLT:  alu_res = XLEN'($signed(fwd_a) < $signed(fwd_b));
            OP_SLL:  alu_res = fwd_a << sh;
            OP_SRL:  alu_res = fwd_a >> sh;
            OP_SRA:  alu_res = XLEN'($signed(fwd_a) >>> sh);
            default: alu_res = '0;
        endcase
    end

    assign mul_start  = (state == IDLE) && valid_in && (alu_op == OP_MUL);
    assign accept_alu = (state != MUL) && valid_in && (alu_op != OP_MUL);
    assign stall_out  = mul_start || (state == MUL);

    mul_seq u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (fwd_a),
        .b       (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE never restarts: the MUL still sitting in ID/EX is the one just finished.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_start) state_nxt = MUL;
            MUL:     if (mul_done || !mul_busy) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result    <= '0;
            hi_out    <= '0;
            rd_out    <= '0;
            valid_out <= 1'b0;
            mul_rd    <= '0;
        end else begin
            valid_out <= 1'b0;
            if (state == MUL) begin
                if (mul_done) begin
                    result    <= mul_prod[XLEN-1:0];
                    hi_out    <= mul_prod[2*XLEN-1:XLEN];
                    rd_out    <= mul_rd;
                    valid_out <= 1'b1;
                end
            end else if (accept_alu) begin
                result    <= alu_res;
                rd_out    <= rd_in;
                valid_out <= 1'b1;
            end
            if (mul_start) begin
                mul_rd <= rd_in;
            end
        end
    end

endmodule
